kth_largest_tracker: RTL and testbench

//  Streaming rank tracker: keeps the K largest samples seen since reset or the

---
 rtl/kth_largest_tracker_if.sv | 34 +++
 rtl/kth_largest_tracker.sv | 107 ++++++++++
 tb/tb_kth_largest_tracker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/kth_largest_tracker_if.sv
// Bus interface for kth_largest_tracker.
// Purpose : groups the sample input, clear, rank select and readout signals
//           of the rank tracker into one bundle.
// Signals : din_valid/din  - sample strobe and value (master -> slave)
//           clear          - synchronous flush of the tracked set (master -> slave)
//           rank_sel       - rank presented on dout, 0 = largest (master -> slave)
//           dout           - value at rank_sel, 0 when not valid (slave -> master)
//           dout_valid     - rank_sel addresses an occupied entry (slave -> master)
//           occ            - number of occupied entries, 0..K (slave -> master)
interface kth_largest_tracker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
);
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(K + 1);

    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  clear;
    logic [RW-1:0]         rank_sel;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [CW-1:0]         occ;

    modport master (
        output din_valid, din, clear, rank_sel,
        input  dout, dout_valid, occ
    );

    modport slave (
        input  din_valid, din, clear, rank_sel,
        output dout, dout_valid, occ
    );
endinterface

// File: rtl/kth_largest_tracker.sv
// Streaming rank tracker.
// Purpose : keeps the K largest samples seen since reset or the last clear in
//           a descending sorted register array t[0..K-1] (t[0] = largest),
//           updated by one-cycle parallel insertion. dout shows the entry at
//           the run-time selected rank.
// Ports   : clk    - rising-edge clock
//           resetn - synchronous active-low reset; discards all history
//           bus    - kth_largest_tracker_if slave modport (din_valid, din,
//                    clear, rank_sel in; dout, dout_valid, occ out)
module kth_largest_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                    clk,
    input  logic                    resetn,
    kth_largest_tracker_if.slave    bus
);
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(K + 1);

    logic [DATA_WIDTH-1:0] t      [K];
    logic [DATA_WIDTH-1:0] base   [K];
    logic [DATA_WIDTH-1:0] t_nxt  [K];
    logic [CW-1:0]         occ_q;
    logic [CW-1:0]         base_occ;
    logic [CW-1:0]         occ_nxt;
    logic [K-1:0]          gt;

    function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
        if (SIGNED)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    // A clear in the same cycle as a sample flushes first, so the insert
    // works on an all-zero, empty array.
    always_comb begin
        base_occ = bus.clear ? '0 : occ_q;
        for (int i = 0; i < K; i++) begin
            base[i] = bus.clear ? '0 : t[i];
        end
    end

    // Empty entries (i >= occupancy) behave as -infinity, so a sample always
    // wins against them; a stored value of 0 there is never compared.
    always_comb begin
        gt = '0;
        for (int i = 0; i < K; i++) begin
            gt[i] = (CW'(i) >= base_occ) || greater(bus.din, base[i]);
        end
    end

    // gt is monotonic down the array (a sample beating entry i-1 also beats
    // entry i), so the first set bit marks the insertion slot and every
    // entry below it shifts down by one.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            t_nxt[i] = base[i];
        end
        occ_nxt = base_occ;
        if (bus.din_valid) begin
            if (gt[0])
                t_nxt[0] = bus.din;
            for (int i = 1; i < K; i++) begin
                if (gt[i - 1])
                    t_nxt[i] = base[i - 1];
                else if (gt[i])
                    t_nxt[i] = bus.din;
            end
            if (base_occ != CW'(K))
                occ_nxt = base_occ + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ_q <= '0;
            for (int i = 0; i < K; i++) begin
                t[i] <= '0;
            end
        end else begin
            occ_q <= occ_nxt;
            for (int i = 0; i < K; i++) begin
                t[i] <= t_nxt[i];
            end
        end
    end

    // Read mux is a decode loop so a rank_sel beyond K-1 (non power-of-two K)
    // never indexes outside the array.
    always_comb begin
        bus.dout       = '0;
        bus.dout_valid = (CW'(bus.rank_sel) < occ_q);
        if (bus.dout_valid) begin
            for (int i = 0; i < K; i++) begin
                if (bus.rank_sel == RW'(i))
                    bus.dout = t[i];
            end
        end
    end

    assign bus.occ = occ_q;

endmodule

// File: tb/tb_kth_largest_tracker.sv
module tb_kth_largest_tracker;
    logic clk;
    logic resetn;

    int checks   = 0;
    int failures = 0;

    kth_largest_tracker_if #(.DATA_WIDTH(32), .K(4)) ua ();
    kth_largest_tracker_if #(.DATA_WIDTH(32), .K(2)) sa ();

    kth_largest_tracker #(.DATA_WIDTH(32), .K(4), .SIGNED(1'b0)) dut_u (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ua.slave)
    );

    kth_largest_tracker #(.DATA_WIDTH(32), .K(2), .SIGNED(1'b1)) dut_s (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sa.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic usel(input int r);
        ua.rank_sel = 2'(r);
        #1;
    endtask

    task automatic ufeed(input logic [31:0] v);
        ua.din_valid = 1'b1;
        ua.din       = v;
        tick();
        ua.din_valid = 1'b0;
    endtask

    task automatic sfeed(input logic [31:0] v);
        sa.din_valid = 1'b1;
        sa.din       = v;
        tick();
        sa.din_valid = 1'b0;
    endtask

    logic [31:0] t1_in   [6] = '{32'd2, 32'd6, 32'd0, 32'd14, 32'd12, 32'd1};
    logic [31:0] t1_dout [6] = '{32'd0, 32'd2, 32'd2, 32'd6, 32'd12, 32'd12};
    logic        t1_v    [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] t1_arr  [4] = '{32'd14, 32'd12, 32'd6, 32'd2};

    initial begin
        resetn       = 1'b0;
        ua.din_valid = 1'b0;
        ua.din       = '0;
        ua.clear     = 1'b0;
        ua.rank_sel  = '0;
        sa.din_valid = 1'b0;
        sa.din       = '0;
        sa.clear     = 1'b0;
        sa.rank_sel  = '0;

        // reset state
        tick();
        tick();
        chk("rst_occ", 32'(ua.occ), 32'd0);
        chk("rst_dv", 32'(ua.dout_valid), 32'd0);
        chk("rst_dout", ua.dout, 32'd0);
        chk("rst_s_occ", 32'(sa.occ), 32'd0);
        resetn = 1'b1;

        // test 1: stream with rank_sel=1
        usel(1);
        for (int i = 0; i < 6; i++) begin
            ufeed(t1_in[i]);
            chk($sformatf("t1_dout_%0d", i), ua.dout, t1_dout[i]);
            chk($sformatf("t1_dv_%0d", i), 32'(ua.dout_valid), 32'(t1_v[i]));
        end
        chk("t1_occ", 32'(ua.occ), 32'd4);

        // test 6: stall with toggling din, then combinational sweep
        for (int i = 0; i < 5; i++) begin
            ua.din = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd100 + 32'(i);
            tick();
            chk($sformatf("stall_occ_%0d", i), 32'(ua.occ), 32'd4);
            chk($sformatf("stall_r1_%0d", i), ua.dout, 32'd12);
        end
        for (int r = 0; r < 4; r++) begin
            usel(r);
            chk($sformatf("sweep_r%0d", r), ua.dout, t1_arr[r]);
            chk($sformatf("sweep_v%0d", r), 32'(ua.dout_valid), 32'd1);
        end

        // test 3: clear with insert, then clear alone
        usel(0);
        ua.clear     = 1'b1;
        ua.din_valid = 1'b1;
        ua.din       = 32'd7;
        tick();
        chk("clr_ins_occ", 32'(ua.occ), 32'd1);
        chk("clr_ins_r0", ua.dout, 32'd7);
        usel(1);
        chk("clr_ins_r1_v", 32'(ua.dout_valid), 32'd0);
        usel(0);
        ua.din_valid = 1'b0;
        tick();
        ua.clear = 1'b0;
        chk("clr_occ", 32'(ua.occ), 32'd0);
        chk("clr_dv", 32'(ua.dout_valid), 32'd0);
        chk("clr_dout", ua.dout, 32'd0);

        // test 2: duplicates
        ufeed(32'd5);
        ufeed(32'd5);
        ufeed(32'd5);
        chk("dup_occ", 32'(ua.occ), 32'd3);
        for (int r = 0; r < 3; r++) begin
            usel(r);
            chk($sformatf("dup_r%0d", r), ua.dout, 32'd5);
        end
        usel(3);
        chk("dup_r3_dout", ua.dout, 32'd0);
        chk("dup_r3_dv", 32'(ua.dout_valid), 32'd0);

        // fill to K, then equal-to-tail (dropped) and just-above-tail inserts
        ufeed(32'd9);
        chk("full_occ", 32'(ua.occ), 32'd4);
        chk("full_r3", ua.dout, 32'd5);
        ufeed(32'd5);
        chk("eq_tail_occ", 32'(ua.occ), 32'd4);
        chk("eq_tail_r3", ua.dout, 32'd5);
        usel(0);
        chk("eq_tail_r0", ua.dout, 32'd9);
        ufeed(32'd6);
        usel(1);
        chk("gt_tail_r1", ua.dout, 32'd6);
        usel(3);
        chk("gt_tail_r3", ua.dout, 32'd5);
        ufeed(32'd200);
        usel(0);
        chk("new_max_r0", ua.dout, 32'd200);
        usel(3);
        chk("new_max_r3", ua.dout, 32'd5);

        // test 4: reset mid-stream with a sample present
        resetn       = 1'b0;
        ua.din_valid = 1'b1;
        ua.din       = 32'd99;
        tick();
        resetn       = 1'b1;
        ua.din_valid = 1'b0;
        usel(0);
        chk("rst_mid_occ", 32'(ua.occ), 32'd0);
        chk("rst_mid_dv", 32'(ua.dout_valid), 32'd0);
        chk("rst_mid_dout", ua.dout, 32'd0);
        tick();
        chk("rst_mid_hold_occ", 32'(ua.occ), 32'd0);

        // test 5: signed, K=2
        sfeed(32'hFFFF_FFFD);
        sfeed(32'hFFFF_FFFF);
        sfeed(32'hFFFF_FFF8);
        chk("s_occ", 32'(sa.occ), 32'd2);
        sa.rank_sel = 1'b0;
        #1;
        chk("s_r0", sa.dout, 32'hFFFF_FFFF);
        sa.rank_sel = 1'b1;
        #1;
        chk("s_r1", sa.dout, 32'hFFFF_FFFD);
        sfeed(32'd0);
        chk("s0_r1", sa.dout, 32'hFFFF_FFFF);
        chk("s0_r1_v", 32'(sa.dout_valid), 32'd1);
        sa.rank_sel = 1'b0;
        #1;
        chk("s0_r0", sa.dout, 32'd0);
        chk("s0_r0_v", 32'(sa.dout_valid), 32'd1);
        chk("s_u_untouched", 32'(ua.occ), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
